fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction-fetch stage of the pipelined CPU, directly upstream of the IF/ID pipeline register. It owns the program counter, issues word fetches to instruction memory over a valid/ready request channel with in-order, variable-latency responses, and buffers returned instructions in a small FIFO. It presents one instruction and its PC per cycle to IF/ID, holds them under decode stall, and squashes everything in flight on a branch redirect.

## Interface
- PC_RESET, 64'h0, PC value loaded on reset; bits [1:0] must be 0.
- FIFO_DEPTH, 2, instruction buffer entries; also the maximum number of outstanding requests (credit limit); power of two, ≥2.
- clk  in  1  clock, all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts the request this cycle.
- imem_req_addr  out  64  word-aligned fetch address; equals the PC register.
- imem_rsp_valid  in  1  response valid; responses return in request order.
- imem_rsp_data  in  32  instruction word.
- redirect_valid  in  1  branch or exception redirect from a later stage.
- redirect_pc  in  64  new PC; bits [1:0] are ignored and forced to 0.
- stall_id  in  1  IF/ID cannot accept this cycle.
- instr_valid  out  1  instr/pc_if valid; low means IF/ID captures a bubble.
- instr  out  32  instruction at FIFO head.
- pc_if  out  64  PC of instr; drives IF/ID pc input.
- stall_cycles  out  32  only with FETCH_PERF_EN.

## Operation
- Credits: outstanding + occupancy < FIFO_DEPTH is required to request. Outstanding counts accepted requests not yet answered or dropped; occupancy is the FIFO count. A response therefore always has a free slot.
- imem_req_valid = credit available && !redirect_valid && !reset. On a handshake (valid && ready), PC ← PC + 4 and outstanding increments.
- Response: if drop_cnt = 0, the word and its PC are pushed into the FIFO; otherwise it is discarded and drop_cnt decrements. Either way, outstanding decrements.
- Response PCs come from a second queue of request addresses, or from a resp_pc register that increments by 4 per accepted response and is reloaded on redirect.
- Pop: occurs when instr_valid && !stall_id.
- Redirect, which has highest priority:
  - PC ← redirect_pc & ~3.
  - FIFO cleared; any same-cycle pop or push is ignored.
  - drop_cnt ← outstanding − (same-cycle response ? 1 : 0) + (same-cycle accepted request ? 0, because req_valid is low).
  - Requests in the redirect cycle are suppressed.
- Simultaneous push and pop on a non-empty FIFO keeps occupancy unchanged. Push into an empty FIFO is visible the next cycle; there is no bypass.
- Redirect is legal at any time, including while stall_id is high and while drop_cnt is nonzero; drop_cnt accumulates correctly.
- PC arithmetic is modulo 2^64. 0xFFFF_FFFF_FFFF_FFFC + 4 wraps to 0.

## Timing
- Reset values:
  - PC = PC_RESET; resp_pc = PC_RESET.
  - imem_req_valid = 0; instr_valid = 0; instr = 0; pc_if = 0.
  - outstanding = 0; drop_cnt = 0; stall_cycles = 0.
- First request is in the first cycle after reset deasserts. Reset mid-operation discards all state; responses to pre-reset requests are the memory's responsibility and must not arrive after reset.
- Latency: a response in cycle N gives instr_valid in N+1, assuming an empty FIFO.
- Redirect in cycle N:
  - instr_valid = 0 in N+1.
  - First request to the new PC in N+1.
  - With 1-cycle memory, the new instruction is at IF/ID input in N+3.
- Under a stall, instr and pc_if are held stable.

## Configuration
- FETCH_PERF_EN:
  - Defined: stall_cycles counts cycles with instr_valid && stall_id. It saturates at 2^32−1 and clears on reset.
  - Undefined: the port and counter are absent.

## Structure
- fetch_pkg:
  - INSTR_W = 32, ADDR_W = 64.
  - typedef fetch_entry_t {pc, instr}.
  - PC_STEP = 4.
- Sub-module fetch_fifo:
  - Parameterised by depth and entry type.
  - Ports: push, pop, clear, full, empty, count, head.
  - Circular pointers with wrap.

## Test plan
- Reset with PC_RESET = 0x1000, 1-cycle memory, no stall → requests at 0x1000, 0x1004, 0x1008…; instr_valid from the third cycle after reset; pc_if increments by 4 each cycle.
- imem_req_ready low for 5 cycles → imem_req_addr held at 0x1008; no PC skip; instr_valid drops only after the FIFO drains.
- stall_id high for 4 cycles with FIFO_DEPTH = 2 → at most 2 outstanding plus buffered; instr/pc_if stable; no lost or duplicated instruction after release.
- 3-cycle memory, 2 requests outstanding, redirect to 0x2002 → both old responses dropped; next pc_if = 0x2000; instr_valid low until the 0x2000 response returns.
- Redirect coincident with a response and a pop, then a second redirect to 0x3000 one cycle later → only 0x3000-stream instructions appear; drop_cnt returns to 0.
- PC = 0xFFFF_FFFF_FFFF_FFF8 → fetches …FFF8, …FFFC, 0x0; FETCH_PERF_EN build with 7 stalled valid cycles → stall_cycles = 7.

Source files
------------

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction-fetch stage.
// Optional feature macro used by fetch_stage: FETCH_PERF_EN.
package fetch_pkg;

   localparam int INSTR_W = 32;
   localparam int ADDR_W  = 64;

   localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(4);

   typedef struct packed {
      logic [ADDR_W-1:0]  pc;
      logic [INSTR_W-1:0] instr;
   } fetch_entry_t;

   function automatic logic [ADDR_W-1:0] word_align(
      input logic [ADDR_W-1:0] a
   );
      return a & ~ADDR_W'(3);
   endfunction

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: circular instruction buffer with clear, no bypass.
// Depth must be a power of two so the pointers wrap naturally.
module fetch_fifo
   import fetch_pkg::*;
#(
   parameter int  DEPTH   = 2,
   parameter type entry_t = fetch_entry_t,
   localparam int PTR_W   = $clog2(DEPTH),
   localparam int CNT_W   = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic             clear,
   input  entry_t           din,
   output logic             full,
   output logic             empty,
   output logic [CNT_W-1:0] count,
   output entry_t           head
);

   entry_t           mem [DEPTH];
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == CNT_W'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign head    = mem[rd_ptr];

   // pointer and occupancy update; clear overrides push and pop
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (clear) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         unique case ({do_push, do_pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // entry storage, written only on an accepted push
   always_ff @(posedge clk) begin
      if (do_push && !clear) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: PC owner, credit-limited imem requests, instruction buffer.
// Define FETCH_PERF_EN to add the stall_cycles counter port.
module fetch_stage
   import fetch_pkg::*;
#(
   parameter logic [ADDR_W-1:0] PC_RESET   = '0,
   parameter int                FIFO_DEPTH = 2
) (
   input  logic               clk,
   input  logic               reset,
   output logic               imem_req_valid,
   input  logic               imem_req_ready,
   output logic [ADDR_W-1:0]  imem_req_addr,
   input  logic               imem_rsp_valid,
   input  logic [INSTR_W-1:0] imem_rsp_data,
   input  logic               redirect_valid,
   input  logic [ADDR_W-1:0]  redirect_pc,
   input  logic               stall_id,
   output logic               instr_valid,
   output logic [INSTR_W-1:0] instr,
   output logic [ADDR_W-1:0]  pc_if
`ifdef FETCH_PERF_EN
   ,
   output logic [31:0]        stall_cycles
`endif
);

   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

   logic [ADDR_W-1:0] pc_q;
   logic [ADDR_W-1:0] resp_pc;
   logic [CNT_W-1:0]  outstanding;
   logic [CNT_W-1:0]  drop_cnt;
   logic [CNT_W-1:0]  fifo_count;
   logic [CNT_W:0]    inflight;
   logic              fifo_full;
   logic              fifo_empty;
   fetch_entry_t      fifo_head;
   fetch_entry_t      fifo_din;
   logic              credit;
   logic              req_fire;
   logic              rsp_drop;
   logic              push;
   logic              pop;

   assign inflight = {1'b0, outstanding} + {1'b0, fifo_count};
   assign credit   = inflight < (CNT_W + 1)'(FIFO_DEPTH);

   assign imem_req_valid = credit && !redirect_valid && !reset;
   assign imem_req_addr  = pc_q;
   assign req_fire       = imem_req_valid && imem_req_ready;

   assign rsp_drop = imem_rsp_valid && (drop_cnt != '0);
   assign push     = imem_rsp_valid && (drop_cnt == '0)
                     && !redirect_valid && !fifo_full;

   assign instr_valid = !fifo_empty;
   assign pop         = instr_valid && !stall_id;
   assign instr       = fifo_empty ? '0 : fifo_head.instr;
   assign pc_if       = fifo_empty ? '0 : fifo_head.pc;

   assign fifo_din = '{pc: resp_pc, instr: imem_rsp_data};

   fetch_fifo #(
      .DEPTH   (FIFO_DEPTH),
      .entry_t (fetch_entry_t)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .pop   (pop),
      .clear (redirect_valid),
      .din   (fifo_din),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count),
      .head  (fifo_head)
   );

   // fetch PC: redirect wins, otherwise advance on each accepted request
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc_q <= PC_RESET;
      end else if (redirect_valid) begin
         pc_q <= word_align(redirect_pc);
      end else if (req_fire) begin
         pc_q <= pc_q + PC_STEP;
      end
   end

   // PC tag for the next kept response; dropped responses never advance it
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         resp_pc <= PC_RESET;
      end else if (redirect_valid) begin
         resp_pc <= word_align(redirect_pc);
      end else if (push) begin
         resp_pc <= resp_pc + PC_STEP;
      end
   end

   // requests accepted by memory and not yet answered
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         outstanding <= '0;
      end else begin
         unique case ({req_fire, imem_rsp_valid})
            2'b10:   outstanding <= outstanding + CNT_W'(1);
            2'b01:   outstanding <= outstanding - CNT_W'(1);
            default: outstanding <= outstanding;
         endcase
      end
   end

   // responses still owed to squashed requests; redirect reloads the count
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         drop_cnt <= '0;
      end else if (redirect_valid) begin
         drop_cnt <= outstanding - CNT_W'(imem_rsp_valid);
      end else if (rsp_drop) begin
         drop_cnt <= drop_cnt - CNT_W'(1);
      end
   end

`ifdef FETCH_PERF_EN
   // saturating count of cycles a valid instruction waited on decode
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stall_cycles <= '0;
      end else if (instr_valid && stall_id && (stall_cycles != '1)) begin
         stall_cycles <= stall_cycles + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: table, directed and random checks of fetch_stage
// against a queue-based model of request/response/buffer behaviour.
module tb_fetch_stage;
   import fetch_pkg::*;

   localparam logic [63:0] PCR   = 64'h1000;
   localparam int          DEPTH = 2;

   logic        clk;
   logic        reset;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [63:0] imem_req_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        redirect_valid;
   logic [63:0] redirect_pc;
   logic        stall_id;
   logic        instr_valid;
   logic [31:0] instr;
   logic [63:0] pc_if;
`ifdef FETCH_PERF_EN
   logic [31:0] stall_cycles;
`endif

   fetch_stage #(
      .PC_RESET   (PCR),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_req_addr  (imem_req_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .stall_id       (stall_id),
      .instr_valid    (instr_valid),
      .instr          (instr),
      .pc_if          (pc_if)
`ifdef FETCH_PERF_EN
      ,
      .stall_cycles   (stall_cycles)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [63:0] addr;
      int          epoch;
      int          due;
   } req_t;

   typedef struct {
      bit          rdy;
      bit          exp_rv;
      logic [63:0] exp_addr;
      bit          exp_iv;
      logic [63:0] exp_pc;
   } vec_t;

   req_t        mem_q[$];
   logic [63:0] buf_q[$];
   int          cyc;
   int          epoch;
   int          mem_lat;
   int          perf_cnt;
   int          checks;
   int          errors;
   logic [63:0] model_pc;

   function automatic logic [31:0] word_of(input logic [63:0] a);
      return a[31:0] ^ a[63:32] ^ 32'h5EED_0013;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got=%h want=%h", nm, act, exp);
      end
   endtask

   // one clock cycle: drive, sample, compare with model, advance model
   task automatic step(input bit rdy, input bit stl, input bit redir,
                       input logic [63:0] tgt, input bit rsp_ok,
                       output bit s_rv, output logic [63:0] s_addr,
                       output bit s_iv, output logic [63:0] s_pc);
      bit   rsp;
      bit   exp_rv;
      bit   exp_iv;
      req_t h;
      rsp = rsp_ok && (mem_q.size() > 0) && (mem_q[0].due <= cyc);
      imem_req_ready = rdy;
      stall_id       = stl;
      redirect_valid = redir;
      redirect_pc    = tgt;
      imem_rsp_valid = rsp;
      imem_rsp_data  = rsp ? word_of(mem_q[0].addr) : $urandom;
      #2;
      s_rv   = imem_req_valid;
      s_addr = imem_req_addr;
      s_iv   = instr_valid;
      s_pc   = pc_if;
      exp_rv = ((mem_q.size() + buf_q.size()) < DEPTH) && !redir;
      exp_iv = buf_q.size() > 0;
      chk("req_valid", 64'(imem_req_valid), 64'(exp_rv));
      if (exp_rv) chk("req_addr", imem_req_addr, model_pc);
      chk("instr_valid", 64'(instr_valid), 64'(exp_iv));
      if (exp_iv) begin
         chk("pc_if", pc_if, buf_q[0]);
         chk("instr", 64'(instr), 64'(word_of(buf_q[0])));
      end
      if (exp_iv && stl) perf_cnt++;
      if (redir) begin
         if (rsp) void'(mem_q.pop_front());
         buf_q.delete();
         epoch++;
         model_pc = tgt & ~64'h3;
      end else begin
         if (exp_iv && !stl) void'(buf_q.pop_front());
         if (rsp) begin
            h = mem_q.pop_front();
            if (h.epoch == epoch) buf_q.push_back(h.addr);
         end
         if (exp_rv && rdy) begin
            mem_q.push_back('{addr: model_pc, epoch: epoch,
                              due: cyc + mem_lat});
            model_pc = model_pc + 64'd4;
         end
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic do_reset();
      reset          = 1'b1;
      imem_req_ready = 1'b1;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      stall_id       = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      chk("rst_req_valid", 64'(imem_req_valid), 64'd0);
      chk("rst_req_addr", imem_req_addr, PCR);
      chk("rst_instr_valid", 64'(instr_valid), 64'd0);
      chk("rst_instr", 64'(instr), 64'd0);
      chk("rst_pc_if", pc_if, 64'd0);
`ifdef FETCH_PERF_EN
      chk("rst_stall_cycles", 64'(stall_cycles), 64'd0);
`endif
      mem_q.delete();
      buf_q.delete();
      model_pc = PCR;
      epoch    = 0;
      perf_cnt = 0;
      cyc      = 1;
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   task automatic chk_perf();
`ifdef FETCH_PERF_EN
      chk("stall_cycles", 64'(stall_cycles), 64'(perf_cnt));
`endif
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t        tbl[12];
      bit          rv;
      bit          iv;
      bit          hit;
      logic [63:0] ad;
      logic [63:0] pc;
      logic [63:0] pc0;
      logic [63:0] got[$];
      int          lat;

      reset  = 1'b1;
      checks = 0;
      errors = 0;
      mem_lat = 1;

      tbl[0]  = '{1'b1, 1'b1, 64'h1000, 1'b0, 64'h0};
      tbl[1]  = '{1'b1, 1'b1, 64'h1004, 1'b0, 64'h0};
      tbl[2]  = '{1'b1, 1'b0, 64'h0,    1'b1, 64'h1000};
      tbl[3]  = '{1'b0, 1'b1, 64'h1008, 1'b1, 64'h1004};
      tbl[4]  = '{1'b0, 1'b1, 64'h1008, 1'b0, 64'h0};
      tbl[5]  = '{1'b0, 1'b1, 64'h1008, 1'b0, 64'h0};
      tbl[6]  = '{1'b0, 1'b1, 64'h1008, 1'b0, 64'h0};
      tbl[7]  = '{1'b0, 1'b1, 64'h1008, 1'b0, 64'h0};
      tbl[8]  = '{1'b1, 1'b1, 64'h1008, 1'b0, 64'h0};
      tbl[9]  = '{1'b1, 1'b1, 64'h100C, 1'b0, 64'h0};
      tbl[10] = '{1'b1, 1'b0, 64'h0,    1'b1, 64'h1008};
      tbl[11] = '{1'b1, 1'b1, 64'h1010, 1'b1, 64'h100C};

      // startup and ready back-pressure, 1-cycle memory
      do_reset();
      for (int i = 0; i < 12; i++) begin
         step(tbl[i].rdy, 1'b0, 1'b0, 64'h0, 1'b1, rv, ad, iv, pc);
         chk($sformatf("tbl%0d_rv", i), 64'(rv), 64'(tbl[i].exp_rv));
         if (tbl[i].exp_rv)
            chk($sformatf("tbl%0d_addr", i), ad, tbl[i].exp_addr);
         chk($sformatf("tbl%0d_iv", i), 64'(iv), 64'(tbl[i].exp_iv));
         if (tbl[i].exp_iv)
            chk($sformatf("tbl%0d_pc", i), pc, tbl[i].exp_pc);
      end

      // decode stall for 7 cycles holds the head entry
      do_reset();
      for (int i = 0; i < 10 && buf_q.size() == 0; i++)
         step(1'b1, 1'b0, 1'b0, 64'h0, 1'b1, rv, ad, iv, pc);
      pc0 = PCR;
      for (int i = 0; i < 7; i++) begin
         step(1'b1, 1'b1, 1'b0, 64'h0, 1'b1, rv, ad, iv, pc);
         chk("stall_iv", 64'(iv), 64'd1);
         chk("stall_pc", pc, pc0);
      end
`ifdef FETCH_PERF_EN
      chk("stall_cycles_7", 64'(stall_cycles), 64'd7);
`endif
      for (int i = 0; i < 12; i++)
         step(1'b1, 1'b0, 1'b0, 64'h0, 1'b1, rv, ad, iv, pc);
      chk_perf();

      // 3-cycle memory, redirect while two requests are outstanding
      do_reset();
      mem_lat = 3;
      for (int i = 0; i < 5 && mem_q.size() < 2; i++)
         step(1'b1, 1'b0, 1'b0, 64'h0, 1'b1, rv, ad, iv, pc);
      chk("two_outstanding", 64'(mem_q.size()), 64'd2);
      step(1'b1, 1'b0, 1'b1, 64'h2002, 1'b1, rv, ad, iv, pc);
      hit = 1'b0;
      for (int i = 0; i < 20 && !hit; i++) begin
         step(1'b1, 1'b0, 1'b0, 64'h0, 1'b1, rv, ad, iv, pc);
         if (iv) begin
            hit = 1'b1;
            chk("redir_first_pc", pc, 64'h2000);
         end
      end
      chk("redir_seen", 64'(hit), 64'd1);

      // redirect with same-cycle response and pop, then a second redirect
      do_reset();
      mem_lat = 1;
      hit = 1'b0;
      for (int i = 0; i < 20 && !hit; i++) begin
         if (buf_q.size() > 0 && mem_q.size() > 0 && mem_q[0].due <= cyc) begin
            step(1'b1, 1'b0, 1'b1, 64'h2800, 1'b1, rv, ad, iv, pc);
            hit = 1'b1;
         end else begin
            step(1'b1, 1'b0, 1'b0, 64'h0, 1'b1, rv, ad, iv, pc);
         end
      end
      chk("coincide_found", 64'(hit), 64'd1);
      step(1'b1, 1'b0, 1'b1, 64'h3000, 1'b1, rv, ad, iv, pc);
      hit = 1'b0;
      for (int i = 0; i < 20; i++) begin
         step(1'b1, 1'b0, 1'b0, 64'h0, 1'b1, rv, ad, iv, pc);
         if (iv && !hit) begin
            hit = 1'b1;
            chk("redir2_first_pc", pc, 64'h3000);
         end
      end
      chk("redir2_seen", 64'(hit), 64'd1);

      // PC wrap at the top of the address space
      step(1'b1, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFF8, 1'b1, rv, ad, iv, pc);
      got.delete();
      for (int i = 0; i < 30 && got.size() < 3; i++) begin
         step(1'b1, 1'b0, 1'b0, 64'h0, 1'b1, rv, ad, iv, pc);
         if (iv) got.push_back(pc);
      end
      chk("wrap_count", 64'(got.size()), 64'd3);
      if (got.size() == 3) begin
         chk("wrap_pc0", got[0], 64'hFFFF_FFFF_FFFF_FFF8);
         chk("wrap_pc1", got[1], 64'hFFFF_FFFF_FFFF_FFFC);
         chk("wrap_pc2", got[2], 64'h0);
      end

      // random traffic against the model, one mid-run reset
      for (int ph = 0; ph < 4; ph++) begin
         if (ph == 2) do_reset();
         lat = 1 + int'($urandom % 4);
         mem_lat = lat;
         for (int i = 0; i < 600; i++) begin
            step($urandom % 100 < 70, $urandom % 100 < 30,
                 $urandom % 100 < 4, {$urandom, $urandom},
                 $urandom % 100 < 75, rv, ad, iv, pc);
         end
         chk_perf();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
